multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Next-generation multicycle MIPS control unit: FSM plus ALU decoder in one block, driving the shared-memory datapath.
- Adds over the previous controller:
  - variable-latency memory handshake (request/ready) with a watchdog timeout
  - bne, addi, andi, ori, slti, j
  - sticky illegal-instruction halt
- Sits between the instruction register (op/funct) and datapath muxes/enables.

Parameters:
- MEM_TIMEOUT, 255, max cycles a memory state waits for i_memready before error; 0 disables watchdog
- TMO_W, 8, width of watchdog counter; MEM_TIMEOUT must fit in TMO_W bits
- CNT_W, 32, width of performance counters (optional feature only)

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_op  in  6  instruction opcode [31:26]
- i_funct  in  6  instruction funct [5:0]
- i_zero  in  1  ALU zero flag
- i_memready  in  1  memory completes current access this cycle
- o_memreq  out  1  memory access request
- o_memwrite  out  1  access is a write (valid with o_memreq)
- o_iord  out  1  address from ALUOut (1) / PC (0)
- o_instrwrite  out  1  IR load enable
- o_pcen  out  1  PC load enable
- o_pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- o_alusrca  out  1  A reg (1) / PC (0)
- o_alusrcb  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
- o_zeroext  out  1  immediate zero-extended instead of sign-extended
- o_alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- o_regwrite  out  1  register file write enable
- o_regdst  out  1  dest rd (1) / rt (0)
- o_memtoreg  out  1  writeback from MDR (1) / ALUOut (0)
- o_illegal  out  1  sticky: undecodable op/funct seen
- o_memerr  out  1  sticky: memory watchdog expired

Behaviour:
- Reset: state <= FETCH; watchdog counter, o_illegal, o_memerr <= 0. While i_reset high, every output is forced to 0 regardless of state.
- Outputs are combinational from state, i_op, i_funct, i_zero, i_memready. No output register.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, slti 001010, andi 001100, ori 001101, j 000010. Any other opcode is illegal.
- R-type funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct is illegal.
- States and actions:
  - FETCH:
    - o_memreq=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
    - instrwrite and pcen asserted only in the cycle i_memready=1; state holds otherwise.
    - i_memready=1 -> DECODE.
  - DECODE:
    - alusrca=0, alusrcb=11, add.
    - lw/sw -> MEMADR; R -> EXEC; beq/bne -> BRANCH; addi/slti/andi/ori -> IEXEC; j -> JUMP; illegal -> HALT.
  - MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: o_memreq=1, iord=1. Holds until i_memready -> MEMWB.
  - MEMWB: regwrite=1, regdst=0, memtoreg=1 -> FETCH.
  - MEMWR: o_memreq=1, o_memwrite=1, iord=1. Holds until i_memready -> FETCH.
  - EXEC:
    - alusrca=1, alusrcb=00, alucontrol from funct.
    - Illegal funct -> HALT; otherwise -> ALUWB.
  - ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
  - BRANCH:
    - alusrca=1, alusrcb=00, sub, pcsrc=01.
    - o_pcen = i_zero for beq, ~i_zero for bne.
    - -> FETCH.
  - IEXEC:
    - alusrca=1, alusrcb=10.
    - addi add, slti slt, andi and, ori or.
    - o_zeroext=1 for andi/ori only.
    - -> IWB.
  - IWB:
    - regwrite=1, regdst=0, memtoreg=0.
    - o_zeroext held as in IEXEC.
    - -> FETCH.
  - JUMP: pcsrc=10, pcen=1 -> FETCH.
  - HALT: all enables 0, o_illegal=1. Stays until reset.
  - MEMERR: all enables 0, o_memerr=1. Stays until reset.
- Every output not listed for a state is 0.
- Watchdog (FETCH, MEMRD, MEMWR):
  - Counter clears on entry to the state and whenever i_memready=1; increments each waiting cycle.
  - With MEM_TIMEOUT!=0: counter == MEM_TIMEOUT and i_memready=0 -> MEMERR.
  - i_memready in the same cycle as expiry wins; the access completes.
- i_memready outside memory states is ignored.
- Reset mid-access: request drops in the reset cycle; FETCH restarts, no partial writeback.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined:
  - adds outputs o_cyclecnt (CNT_W) and o_instret (CNT_W); both reset to 0.
  - o_cyclecnt increments every non-reset cycle outside HALT/MEMERR.
  - o_instret increments on each transition into FETCH from a completing state: MEMWB, MEMWR done, ALUWB, BRANCH, IWB, JUMP.
  - Both counters wrap modulo 2^CNT_W.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- add (op 000000, funct 100000), i_memready=1 always -> FETCH,DECODE,EXEC,ALUWB: 4 cycles, alucontrol=010 in EXEC, regwrite+regdst=1 in ALUWB.
- lw with i_memready low 3 cycles in MEMRD -> o_memreq held 4 cycles, no regwrite until MEMWB; total 8 cycles.
- bne with i_zero=0 -> o_pcen=1, pcsrc=01 in BRANCH. Repeat with i_zero=1 -> o_pcen=0.
- andi (001100) -> o_zeroext=1 and alucontrol=000 in IEXEC, regwrite=1, regdst=0 in IWB.
- op 111111 -> HALT, o_illegal=1 sticky for 20 cycles; i_reset pulse -> 0, FETCH resumes.
- MEM_TIMEOUT=4, i_memready held 0 in FETCH -> MEMERR after 4 wait cycles, o_memerr=1. With PERF_EN, o_instret stops incrementing.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [5:0] i_op;
  logic [5:0] i_funct;
  logic       i_zero;
  logic       i_memready;

  logic       o_memreq;
  logic       o_memwrite;
  logic       o_iord;
  logic       o_instrwrite;
  logic       o_pcen;
  logic [1:0] o_pcsrc;
  logic       o_alusrca;
  logic [1:0] o_alusrcb;
  logic       o_zeroext;
  logic [2:0] o_alucontrol;
  logic       o_regwrite;
  logic       o_regdst;
  logic       o_memtoreg;
  logic       o_illegal;
  logic       o_memerr;

  modport master (
    input  i_op, i_funct, i_zero, i_memready,
    output o_memreq, o_memwrite, o_iord, o_instrwrite, o_pcen, o_pcsrc,
           o_alusrca, o_alusrcb, o_zeroext, o_alucontrol, o_regwrite,
           o_regdst, o_memtoreg, o_illegal, o_memerr
  );

  modport slave (
    output i_op, i_funct, i_zero, i_memready,
    input  o_memreq, o_memwrite, o_iord, o_instrwrite, o_pcen, o_pcsrc,
           o_alusrca, o_alusrcb, o_zeroext, o_alucontrol, o_regwrite,
           o_regdst, o_memtoreg, o_illegal, o_memerr
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS controller: FSM + ALU decoder with memory handshake watchdog.
// Define MULTICYCLE_CTRL_PERF_EN to add the cycle / retired-instruction counters.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TMO_W       = 8
`ifdef MULTICYCLE_CTRL_PERF_EN
  , parameter int unsigned CNT_W     = 32
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  multicycle_ctrl_if.master    bus
`ifdef MULTICYCLE_CTRL_PERF_EN
  , output logic [CNT_W-1:0]   o_cyclecnt
  , output logic [CNT_W-1:0]   o_instret
`endif
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_IEXEC, S_IWB, S_JUMP, S_HALT, S_MEMERR
  } state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_expired;
  logic [2:0]       r_aluc;
  logic             r_legal;
  logic [2:0]       imm_aluc;
  logic             logic_imm;

  assign tmo_expired = (MEM_TIMEOUT != 0) && (tmo_cnt == TMO_LIM);
  assign logic_imm   = (bus.i_op == OP_ANDI) || (bus.i_op == OP_ORI);

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    r_aluc  = ALU_AND;
    r_legal = 1'b1;
    case (bus.i_funct)
      F_ADD:   r_aluc = ALU_ADD;
      F_SUB:   r_aluc = ALU_SUB;
      F_AND:   r_aluc = ALU_AND;
      F_OR:    r_aluc = ALU_OR;
      F_SLT:   r_aluc = ALU_SLT;
      default: r_legal = 1'b0;
    endcase

    imm_aluc = ALU_ADD;
    case (bus.i_op)
      OP_SLTI: imm_aluc = ALU_SLT;
      OP_ANDI: imm_aluc = ALU_AND;
      OP_ORI:  imm_aluc = ALU_OR;
      default: imm_aluc = ALU_ADD;
    endcase
  end

  // Watchdog counter clears on every state change (so it starts at 0 on entry)
  // and on completion; it only advances while a memory state is waiting.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= S_FETCH;
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= '0;
      case (state)
        S_FETCH, S_MEMRD, S_MEMWR: begin
          if (bus.i_memready) begin
            case (state)
              S_FETCH: state <= S_DECODE;
              S_MEMRD: state <= S_MEMWB;
              default: state <= S_FETCH;
            endcase
          end else if (tmo_expired) begin
            state <= S_MEMERR;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_DECODE: begin
          case (bus.i_op)
            OP_LW, OP_SW:                        state <= S_MEMADR;
            OP_R:                                state <= S_EXEC;
            OP_BEQ, OP_BNE:                      state <= S_BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:   state <= S_IEXEC;
            OP_J:                                state <= S_JUMP;
            default:                             state <= S_HALT;
          endcase
        end
        S_MEMADR: state <= (bus.i_op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_EXEC:   state <= r_legal ? S_ALUWB : S_HALT;
        S_IEXEC:  state <= S_IWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP: state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        S_MEMERR: state <= S_MEMERR;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.o_memreq     = 1'b0;
    bus.o_memwrite   = 1'b0;
    bus.o_iord       = 1'b0;
    bus.o_instrwrite = 1'b0;
    bus.o_pcen       = 1'b0;
    bus.o_pcsrc      = 2'b00;
    bus.o_alusrca    = 1'b0;
    bus.o_alusrcb    = 2'b00;
    bus.o_zeroext    = 1'b0;
    bus.o_alucontrol = 3'b000;
    bus.o_regwrite   = 1'b0;
    bus.o_regdst     = 1'b0;
    bus.o_memtoreg   = 1'b0;
    bus.o_illegal    = 1'b0;
    bus.o_memerr     = 1'b0;
    if (!i_reset) begin
      case (state)
        S_FETCH: begin
          bus.o_memreq     = 1'b1;
          bus.o_alusrcb    = 2'b01;
          bus.o_alucontrol = ALU_ADD;
          bus.o_instrwrite = bus.i_memready;
          bus.o_pcen       = bus.i_memready;
        end
        S_DECODE: begin
          bus.o_alusrcb    = 2'b11;
          bus.o_alucontrol = ALU_ADD;
        end
        S_MEMADR: begin
          bus.o_alusrca    = 1'b1;
          bus.o_alusrcb    = 2'b10;
          bus.o_alucontrol = ALU_ADD;
        end
        S_MEMRD: begin
          bus.o_memreq = 1'b1;
          bus.o_iord   = 1'b1;
        end
        S_MEMWB: begin
          bus.o_regwrite = 1'b1;
          bus.o_memtoreg = 1'b1;
        end
        S_MEMWR: begin
          bus.o_memreq   = 1'b1;
          bus.o_memwrite = 1'b1;
          bus.o_iord     = 1'b1;
        end
        S_EXEC: begin
          bus.o_alusrca    = 1'b1;
          bus.o_alucontrol = r_aluc;
        end
        S_ALUWB: begin
          bus.o_regwrite = 1'b1;
          bus.o_regdst   = 1'b1;
        end
        S_BRANCH: begin
          bus.o_alusrca    = 1'b1;
          bus.o_alucontrol = ALU_SUB;
          bus.o_pcsrc      = 2'b01;
          bus.o_pcen       = (bus.i_op == OP_BNE) ? ~bus.i_zero : bus.i_zero;
        end
        S_IEXEC: begin
          bus.o_alusrca    = 1'b1;
          bus.o_alusrcb    = 2'b10;
          bus.o_alucontrol = imm_aluc;
          bus.o_zeroext    = logic_imm;
        end
        S_IWB: begin
          bus.o_regwrite = 1'b1;
          bus.o_zeroext  = logic_imm;
        end
        S_JUMP: begin
          bus.o_pcsrc = 2'b10;
          bus.o_pcen  = 1'b1;
        end
        S_HALT:   bus.o_illegal = 1'b1;
        S_MEMERR: bus.o_memerr  = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic retire;

  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                  (state == S_IWB)   || (state == S_JUMP)  ||
                  ((state == S_MEMWR) && bus.i_memready);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_cyclecnt <= '0;
      o_instret  <= '0;
    end else begin
      if ((state != S_HALT) && (state != S_MEMERR))
        o_cyclecnt <= o_cyclecnt + CNT_W'(1);
      if (retire)
        o_instret <= o_instret + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its
// expected per-cycle control trace from the instruction-level rules, then replayed.
module tb_multicycle_ctrl;
  localparam int TMO = 4;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0a;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_J    = 6'h02;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXEC,
    P_ALUWB, P_BRANCH, P_IEXEC, P_IWB, P_JUMP, P_HALT, P_MEMERR
  } ph_t;

  typedef struct {
    ph_t         ph;
    logic        rdy;
    logic        z;
    logic [18:0] exp;
    logic        retire;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_cyc = 0;
  int   m_ret = 0;
  step_t q[$];

  multicycle_ctrl_if bus();

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cyclecnt, instret;
  multicycle_ctrl #(.MEM_TIMEOUT(TMO), .TMO_W(8)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus), .o_cyclecnt(cyclecnt), .o_instret(instret));
`else
  multicycle_ctrl #(.MEM_TIMEOUT(TMO), .TMO_W(8)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus));
`endif

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [18:0] obs;
  assign obs = {bus.o_memreq, bus.o_memwrite, bus.o_iord, bus.o_instrwrite, bus.o_pcen,
                bus.o_pcsrc, bus.o_alusrca, bus.o_alusrcb, bus.o_zeroext, bus.o_alucontrol,
                bus.o_regwrite, bus.o_regdst, bus.o_memtoreg, bus.o_illegal, bus.o_memerr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [18:0] cw(
    input logic memreq, memwrite, iord, instrwrite, pcen, input logic [1:0] pcsrc,
    input logic alusrca, input logic [1:0] alusrcb, input logic zeroext,
    input logic [2:0] aluc, input logic regwrite, regdst, memtoreg, illegal, memerr);
    return {memreq, memwrite, iord, instrwrite, pcen, pcsrc, alusrca, alusrcb,
            zeroext, aluc, regwrite, regdst, memtoreg, illegal, memerr};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void funct_alu(input logic [5:0] f, output logic [2:0] ac, output logic legal);
    legal = 1'b1;
    case (f)
      6'h20:   ac = 3'b010;
      6'h22:   ac = 3'b110;
      6'h24:   ac = 3'b000;
      6'h25:   ac = 3'b001;
      6'h2a:   ac = 3'b111;
      default: begin ac = 3'b000; legal = 1'b0; end
    endcase
  endfunction

  task automatic push(input ph_t ph, input logic rdy, input logic z, input logic [18:0] e, input logic ret);
    step_t s;
    s.ph = ph; s.rdy = rdy; s.z = z; s.exp = e; s.retire = ret;
    q.push_back(s);
  endtask

  task automatic add_stop(input ph_t ph, input int n);
    for (int i = 0; i < n; i++)
      push(ph, rb(), rb(), (ph == P_HALT) ? cw(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,0,0,0,1,0)
                                          : cw(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,0,0,0,0,1), 1'b0);
  endtask

  // A memory state waits `lat` cycles; the wait that finds the counter at TMO without ready is fatal.
  task automatic mem_phase(input ph_t ph, input int lat, input logic [18:0] wait_cw,
                           input logic [18:0] done_cw, input logic ret, output logic err);
    int n;
    err = (lat > TMO);
    n = err ? TMO + 1 : lat;
    for (int i = 0; i < n; i++) push(ph, 1'b0, rb(), wait_cw, 1'b0);
    if (!err) push(ph, 1'b1, rb(), done_cw, ret);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] funct, input int lf,
                       input int lm, input int zsel, output logic term);
    logic err;
    logic [2:0] ac;
    logic legal, z, ze;
    q.delete();
    term = 1'b0;
    mem_phase(P_FETCH, lf, cw(1,0,0,0,0,2'b00,0,2'b01,0,3'b010,0,0,0,0,0),
              cw(1,0,0,1,1,2'b00,0,2'b01,0,3'b010,0,0,0,0,0), 1'b0, err);
    if (err) begin
      add_stop(P_MEMERR, 5); term = 1'b1;
    end else begin
      push(P_DECODE, rb(), rb(), cw(0,0,0,0,0,2'b00,0,2'b11,0,3'b010,0,0,0,0,0), 1'b0);
      case (op)
        OP_LW, OP_SW: begin
          push(P_MEMADR, rb(), rb(), cw(0,0,0,0,0,2'b00,1,2'b10,0,3'b010,0,0,0,0,0), 1'b0);
          if (op == OP_LW) begin
            mem_phase(P_MEMRD, lm, cw(1,0,1,0,0,2'b00,0,2'b00,0,3'b000,0,0,0,0,0),
                      cw(1,0,1,0,0,2'b00,0,2'b00,0,3'b000,0,0,0,0,0), 1'b0, err);
            if (!err) push(P_MEMWB, rb(), rb(), cw(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,1,0,1,0,0), 1'b1);
          end else begin
            mem_phase(P_MEMWR, lm, cw(1,1,1,0,0,2'b00,0,2'b00,0,3'b000,0,0,0,0,0),
                      cw(1,1,1,0,0,2'b00,0,2'b00,0,3'b000,0,0,0,0,0), 1'b1, err);
          end
          if (err) begin add_stop(P_MEMERR, 5); term = 1'b1; end
        end
        OP_R: begin
          funct_alu(funct, ac, legal);
          push(P_EXEC, rb(), rb(), cw(0,0,0,0,0,2'b00,1,2'b00,0,ac,0,0,0,0,0), 1'b0);
          if (legal) push(P_ALUWB, rb(), rb(), cw(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,1,1,0,0,0), 1'b1);
          else begin add_stop(P_HALT, 20); term = 1'b1; end
        end
        OP_BEQ, OP_BNE: begin
          z = (zsel < 0) ? rb() : zsel[0];
          push(P_BRANCH, rb(), z, cw(0,0,0,0,(op == OP_BNE) ? ~z : z,2'b01,1,2'b00,0,3'b110,0,0,0,0,0), 1'b1);
        end
        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
          ac = (op == OP_SLTI) ? 3'b111 : (op == OP_ANDI) ? 3'b000 : (op == OP_ORI) ? 3'b001 : 3'b010;
          ze = (op == OP_ANDI) || (op == OP_ORI);
          push(P_IEXEC, rb(), rb(), cw(0,0,0,0,0,2'b00,1,2'b10,ze,ac,0,0,0,0,0), 1'b0);
          push(P_IWB, rb(), rb(), cw(0,0,0,0,0,2'b00,0,2'b00,ze,3'b000,1,0,0,0,0), 1'b1);
        end
        OP_J: push(P_JUMP, rb(), rb(), cw(0,0,0,0,1,2'b10,0,2'b00,0,3'b000,0,0,0,0,0), 1'b1);
        default: begin add_stop(P_HALT, 20); term = 1'b1; end
      endcase
    end
  endtask

  task automatic perf_check();
`ifdef MULTICYCLE_CTRL_PERF_EN
    check("cyclecnt", cyclecnt, 32'(m_cyc));
    check("instret", instret, 32'(m_ret));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_memready = rb();
    bus.i_zero = rb();
    #1;
    check("reset_outputs", 32'(obs), 32'h0);
    m_cyc = 0;
    m_ret = 0;
  endtask

  task automatic do_step(input step_t s);
    ph_t p;
    p = s.ph;
    @(negedge clk);
    rst = 1'b0;
    bus.i_memready = s.rdy;
    bus.i_zero = s.z;
    #1;
    check(p.name(), 32'(obs), 32'(s.exp));
    perf_check();
    if (p != P_HALT && p != P_MEMERR) m_cyc++;
    if (s.retire) m_ret++;
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] funct, input int lf,
                     input int lm, input int zsel, input int rst_at);
    logic term;
    int i;
    logic aborted;
    bus.i_op = op;
    bus.i_funct = funct;
    build(op, funct, lf, lm, zsel, term);
    i = 0;
    aborted = 1'b0;
    while (!aborted && i < q.size()) begin
      if (i == rst_at) begin
        do_reset();
        aborted = 1'b1;
      end else begin
        do_step(q[i]);
        i++;
      end
    end
    if (!aborted && term) do_reset();
  endtask

  function automatic int rand_lat();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
  endfunction

  logic [5:0] legal_ops [10];
  logic [5:0] legal_fn  [5];

  initial begin
    logic [5:0] op, fn;
    int rst_at;
    legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_J};
    legal_fn  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    bus.i_op = 6'h00;
    bus.i_funct = 6'h20;
    bus.i_zero = 1'b0;
    bus.i_memready = 1'b0;

    do_reset();
    run(OP_R,    6'h20, 0, 0, -1, -1);   // add, zero-wait
    run(OP_LW,   6'h00, 0, 3, -1, -1);   // lw, three wait cycles in MEMRD
    run(OP_BNE,  6'h00, 0, 0,  0, -1);   // bne taken
    run(OP_BNE,  6'h00, 0, 0,  1, -1);   // bne not taken
    run(OP_BEQ,  6'h00, 1, 0,  1, -1);   // beq taken
    run(OP_ANDI, 6'h00, 2, 0, -1, -1);
    run(OP_SW,   6'h00, 0, TMO, -1, -1); // ready arrives exactly at expiry
    run(OP_R,    6'h22, TMO, 0, -1, -1);
    run(6'h3f,   6'h00, 0, 0, -1, -1);   // illegal opcode -> HALT
    run(OP_R,    6'h3f, 0, 0, -1, -1);   // illegal funct -> HALT
    run(OP_ORI,  6'h00, 6, 0, -1, -1);   // fetch watchdog -> MEMERR
    run(OP_LW,   6'h00, 0, 5, -1, -1);   // read watchdog -> MEMERR
    run(OP_LW,   6'h00, 0, 3, -1, 5);    // reset while MEMRD waits
    run(OP_J,    6'h00, 0, 0, -1, -1);

    for (int k = 0; k < 200; k++) begin
      op = ($urandom_range(0, 11) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)];
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
      run(op, fn, rand_lat(), rand_lat(), -1, rst_at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
